// File: rtl/fifo_level_tracker.sv
// Occupancy tracker for inter-core FIFOs: saturating level, registered
// threshold flags, sticky overflow/underflow errors and a high-water mark.
module fifo_level_tracker #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_W     = $clog2(DEPTH + 1),
   parameter int unsigned AF_THRESH = DEPTH - 1,
   parameter int unsigned AE_THRESH = 1
) (
   input  logic             CLK,
   input  logic             FIFOLEVEL_RST,
   input  logic             FIFOLEVEL_CntUpInhibit,
   input  logic             FIFOLEVEL_CntDownInhibit,
   input  logic             FIFOLEVEL_CntUpSignal,
   input  logic             FIFOLEVEL_CntDownSignal,
   input  logic             FIFOLEVEL_ErrClear,
   output logic [CNT_W-1:0] FIFOLEVEL_Level,
   output logic             FIFOLEVEL_Full,
   output logic             FIFOLEVEL_Empty,
   output logic             FIFOLEVEL_AlmostFull,
   output logic             FIFOLEVEL_AlmostEmpty,
   output logic             FIFOLEVEL_Overflow,
   output logic             FIFOLEVEL_Underflow,
   output logic [CNT_W-1:0] FIFOLEVEL_HighWater
);

   localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LVL_AF  = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] LVL_AE  = CNT_W'(AE_THRESH);

   logic [CNT_W-1:0] r_level;
   logic [CNT_W-1:0] r_high_water;
   logic             r_full;
   logic             r_empty;
   logic             r_almost_full;
   logic             r_almost_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_up;
   logic             w_dn;
   logic             w_ovf_evt;
   logic             w_unf_evt;
   logic [CNT_W-1:0] w_level_nxt;
   logic [CNT_W-1:0] w_hw_nxt;

   assign w_up = FIFOLEVEL_CntUpSignal   & ~FIFOLEVEL_CntUpInhibit;
   assign w_dn = FIFOLEVEL_CntDownSignal & ~FIFOLEVEL_CntDownInhibit;

   // Next level; simultaneous up+down is a pass-through at any level.
   always_comb begin
      w_level_nxt = r_level;
      w_ovf_evt   = 1'b0;
      w_unf_evt   = 1'b0;
      if (w_up && !w_dn) begin
         if (r_level == LVL_MAX) begin
            w_ovf_evt = 1'b1;
         end else begin
            w_level_nxt = r_level + CNT_W'(1);
         end
      end else if (w_dn && !w_up) begin
         if (r_level == '0) begin
            w_unf_evt = 1'b1;
         end else begin
            w_level_nxt = r_level - CNT_W'(1);
         end
      end
   end

   // Clear reloads the mark from the next level rather than zero.
   always_comb begin
      w_hw_nxt = r_high_water;
      if (FIFOLEVEL_ErrClear || (w_level_nxt > r_high_water)) begin
         w_hw_nxt = w_level_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (FIFOLEVEL_RST) begin
         r_level        <= '0;
         r_high_water   <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_level        <= w_level_nxt;
         r_high_water   <= w_hw_nxt;
         r_full         <= (w_level_nxt == LVL_MAX);
         r_empty        <= (w_level_nxt == '0);
         r_almost_full  <= (w_level_nxt >= LVL_AF);
         r_almost_empty <= (w_level_nxt <= LVL_AE);
         r_overflow     <= w_ovf_evt | (r_overflow  & ~FIFOLEVEL_ErrClear);
         r_underflow    <= w_unf_evt | (r_underflow & ~FIFOLEVEL_ErrClear);
      end
   end

   assign FIFOLEVEL_Level       = r_level;
   assign FIFOLEVEL_HighWater   = r_high_water;
   assign FIFOLEVEL_Full        = r_full;
   assign FIFOLEVEL_Empty       = r_empty;
   assign FIFOLEVEL_AlmostFull  = r_almost_full;
   assign FIFOLEVEL_AlmostEmpty = r_almost_empty;
   assign FIFOLEVEL_Overflow    = r_overflow;
   assign FIFOLEVEL_Underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_level_tracker.sv
// Directed bench for fifo_level_tracker (DEPTH=4, AF_THRESH=3, AE_THRESH=1)
// with hand-computed expected outputs after every clock edge.
module tb_fifo_level_tracker;

   localparam int unsigned CNT_W = 3;

   logic             clk;
   logic             rst;
   logic             up_inh;
   logic             dn_inh;
   logic             up_sig;
   logic             dn_sig;
   logic             err_clr;
   logic [CNT_W-1:0] level;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;
   logic [CNT_W-1:0] high_water;

   int unsigned n_total;
   int unsigned n_bad;

   fifo_level_tracker #(
      .DEPTH(4)
   ) u_dut (
      .CLK                      (clk),
      .FIFOLEVEL_RST            (rst),
      .FIFOLEVEL_CntUpInhibit   (up_inh),
      .FIFOLEVEL_CntDownInhibit (dn_inh),
      .FIFOLEVEL_CntUpSignal    (up_sig),
      .FIFOLEVEL_CntDownSignal  (dn_sig),
      .FIFOLEVEL_ErrClear       (err_clr),
      .FIFOLEVEL_Level          (level),
      .FIFOLEVEL_Full           (full),
      .FIFOLEVEL_Empty          (empty),
      .FIFOLEVEL_AlmostFull     (almost_full),
      .FIFOLEVEL_AlmostEmpty    (almost_empty),
      .FIFOLEVEL_Overflow       (overflow),
      .FIFOLEVEL_Underflow      (underflow),
      .FIFOLEVEL_HighWater      (high_water)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then compare every output just after the edge.
   // flags = {full, empty, almost_full, almost_empty, overflow, underflow}
   task automatic step(input string tag,
                       input logic i_rst, input logic i_up, input logic i_dn,
                       input logic i_ui, input logic i_di, input logic i_clr,
                       input int unsigned e_lvl, input logic [5:0] e_flags,
                       input int unsigned e_hw);
      rst     = i_rst;
      up_sig  = i_up;
      dn_sig  = i_dn;
      up_inh  = i_ui;
      dn_inh  = i_di;
      err_clr = i_clr;
      @(posedge clk);
      #1;
      check({tag, ".level"}, 32'(level),        e_lvl);
      check({tag, ".full"},  32'(full),         32'(e_flags[5]));
      check({tag, ".empty"}, 32'(empty),        32'(e_flags[4]));
      check({tag, ".af"},    32'(almost_full),  32'(e_flags[3]));
      check({tag, ".ae"},    32'(almost_empty), 32'(e_flags[2]));
      check({tag, ".ovf"},   32'(overflow),     32'(e_flags[1]));
      check({tag, ".unf"},   32'(underflow),    32'(e_flags[0]));
      check({tag, ".hw"},    32'(high_water),   e_hw);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1; up_sig = 1'b0; dn_sig = 1'b0;
      up_inh = 1'b0; dn_inh = 1'b0; err_clr = 1'b0;

      //          tag       rst up dn ui di clr lvl  F E AF AE O U      hw
      step("reset",   1, 0, 0, 0, 0, 0, 0, 6'b010100, 0);
      step("fill1",   0, 1, 0, 0, 0, 0, 1, 6'b000100, 1);
      step("fill2",   0, 1, 0, 0, 0, 0, 2, 6'b000000, 2);
      step("fill3",   0, 1, 0, 0, 0, 0, 3, 6'b001000, 3);
      step("fill4",   0, 1, 0, 0, 0, 0, 4, 6'b101000, 4);
      step("ovf",     0, 1, 0, 0, 0, 0, 4, 6'b101010, 4);
      step("ovf_dn",  0, 0, 1, 0, 0, 0, 3, 6'b001010, 4);
      step("clr_ovf", 0, 0, 0, 0, 0, 1, 3, 6'b001000, 3);
      step("drain2",  0, 0, 1, 0, 0, 0, 2, 6'b000000, 3);
      step("drain1",  0, 0, 1, 0, 0, 0, 1, 6'b000100, 3);
      step("drain0",  0, 0, 1, 0, 0, 0, 0, 6'b010100, 3);
      step("unf",     0, 0, 1, 0, 0, 0, 0, 6'b010101, 3);
      step("ud_at0",  0, 1, 1, 0, 0, 0, 0, 6'b010101, 3);
      step("clr_unf", 0, 0, 0, 0, 0, 1, 0, 6'b010100, 0);
      step("ud0_clr", 0, 1, 1, 0, 0, 0, 0, 6'b010100, 0);
      step("refill1", 0, 1, 0, 0, 0, 0, 1, 6'b000100, 1);
      step("refill2", 0, 1, 0, 0, 0, 0, 2, 6'b000000, 2);
      step("refill3", 0, 1, 0, 0, 0, 0, 3, 6'b001000, 3);
      step("refill4", 0, 1, 0, 0, 0, 0, 4, 6'b101000, 4);
      step("ud_at4",  0, 1, 1, 0, 0, 0, 4, 6'b101000, 4);
      step("dn_to3",  0, 0, 1, 0, 0, 0, 3, 6'b001000, 4);
      step("dn_to2",  0, 0, 1, 0, 0, 0, 2, 6'b000000, 4);
      step("up_inh",  0, 1, 0, 1, 0, 0, 2, 6'b000000, 4);
      step("dn_inh",  0, 0, 1, 0, 1, 0, 2, 6'b000000, 4);
      step("ud_dinh", 0, 1, 1, 0, 1, 0, 3, 6'b001000, 4);
      step("ud_uinh", 0, 1, 1, 1, 0, 0, 2, 6'b000000, 4);
      step("to1",     0, 0, 1, 0, 0, 0, 1, 6'b000100, 4);
      step("to0",     0, 0, 1, 0, 0, 0, 0, 6'b010100, 4);
      step("unf_clr", 0, 0, 1, 0, 0, 1, 0, 6'b010101, 0);
      step("f3_1",    0, 1, 0, 0, 0, 0, 1, 6'b000101, 1);
      step("f3_2",    0, 1, 0, 0, 0, 0, 2, 6'b000001, 2);
      step("f3_3",    0, 1, 0, 0, 0, 0, 3, 6'b001001, 3);
      step("rst_up",  1, 1, 0, 0, 0, 0, 0, 6'b010100, 0);
      step("post_up", 0, 1, 0, 0, 0, 0, 1, 6'b000100, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
